// File: rtl/shift_register_controller_pkg.sv
// Shared definitions for the shift register controller: FSM state encoding
// and the fill-mode codes selecting the bit that enters bit 0 on each shift.
package shift_register_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [1:0] FILL_ZERO   = 2'b00;
    localparam logic [1:0] FILL_ONE    = 2'b01;
    localparam logic [1:0] FILL_SERIAL = 2'b10;
    localparam logic [1:0] FILL_ROTATE = 2'b11;

endpackage

// File: rtl/shift_register_controller_datapath.sv
// WIDTH-bit register with synchronous parallel load and a left shift
// (bit 0 toward bit WIDTH-1) that takes fill_bit into bit 0.
// Ports:
//   clk, rst_n   clock and asynchronous active-low clear
//   load_en      load load_value on the next edge (wins over shift_en)
//   load_value   parallel preset word
//   shift_en     shift one place on the next edge
//   fill_bit     bit entering bit 0 during a shift
//   data_out     register contents
module shift_datapath #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift_en,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next register value: load has priority over shift.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = load_value;
        end else if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], fill_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/shift_register_controller.sv
// Sequencing controller for the shift register datapath. Accepts a command
// (preset word, shift count, fill mode) on start while ready, presets the
// register, shifts it the requested number of times and pulses done.
// Ports:
//   clockpulse, clear          clock and asynchronous active-low reset
//   start / ready              command handshake
//   loadWord, shiftCount,      command payload sampled on acceptance
//   fillMode                   (count clamps to WIDTH)
//   serialInput                live serial bit used by the serial fill mode
//   hold                       freezes shifting while high
//   dataOut                    register contents
//   serialOutput, serialValid  bit leaving bit WIDTH-1 and its strobe
//   done                       one-cycle completion pulse
module shift_register_controller
    import shift_register_controller_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                   clockpulse,
    input  logic                   clear,
    input  logic                   start,
    output logic                   ready,
    input  logic [WIDTH-1:0]       loadWord,
    input  logic [COUNT_WIDTH-1:0] shiftCount,
    input  logic [1:0]             fillMode,
    input  logic                   serialInput,
    input  logic                   hold,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   serialOutput,
    output logic                   serialValid,
    output logic                   done
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(WIDTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_e                 state_q;
    state_e                 state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [1:0]             fill_q;
    logic [1:0]             fill_d;
    logic                   ready_q;
    logic                   ready_d;
    logic                   done_q;
    logic                   done_d;
    logic                   ser_out_q;
    logic                   ser_out_d;
    logic                   ser_valid_q;
    logic                   ser_valid_d;

    logic                   load_en_c;
    logic                   shift_en_c;
    logic                   fill_bit_c;
    logic [COUNT_WIDTH-1:0] clamped_count_c;
    logic [WIDTH-1:0]       data_w;

    shift_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clockpulse),
        .rst_n      (clear),
        .load_en    (load_en_c),
        .load_value (loadWord),
        .shift_en   (shift_en_c),
        .fill_bit   (fill_bit_c),
        .data_out   (data_w)
    );

    // Requested count saturated at the register width.
    always_comb begin
        clamped_count_c = shiftCount;
        if (shiftCount > COUNT_MAX) begin
            clamped_count_c = COUNT_MAX;
        end
    end

    // Fill bit select; rotate feeds back the pre-shift MSB.
    always_comb begin
        fill_bit_c = 1'b0;
        case (fill_q)
            FILL_ZERO:   fill_bit_c = 1'b0;
            FILL_ONE:    fill_bit_c = 1'b1;
            FILL_SERIAL: fill_bit_c = serialInput;
            FILL_ROTATE: fill_bit_c = data_w[WIDTH-1];
            default:     fill_bit_c = 1'b0;
        endcase
    end

    // Next-state and registered-output logic. ready/done are registered,
    // so done appears the cycle after DONE and ready the cycle after that.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fill_d      = fill_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        load_en_c   = 1'b0;
        shift_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                // ready_q is low on the done cycle, so start is ignored there.
                if (start && ready_q) begin
                    load_en_c = 1'b1;
                    count_d   = clamped_count_c;
                    fill_d    = fillMode;
                    ready_d   = 1'b0;
                    if (clamped_count_c == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                ready_d = 1'b0;
                if (!hold) begin
                    shift_en_c  = 1'b1;
                    ser_out_d   = data_w[WIDTH-1];
                    ser_valid_d = 1'b1;
                    count_d     = count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                ready_d = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            fill_q      <= FILL_ZERO;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign serialOutput = ser_out_q;
    assign serialValid  = ser_valid_q;
    assign dataOut      = data_w;

endmodule

// File: tb/tb_shift_register_controller.sv
// Bench for shift_register_controller: directed command scenarios plus
// randomized commands checked against a cycle-level behavioural model.
module tb_shift_register_controller;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          clear;
    logic          start;
    logic          ready;
    logic [W-1:0]  load_word;
    logic [CW-1:0] shift_count;
    logic [1:0]    fill_mode;
    logic          serial_input;
    logic          hold;
    logic [W-1:0]  data_out;
    logic          serial_output;
    logic          serial_valid;
    logic          done;

    int checks = 0;
    int errors = 0;

    shift_register_controller #(
        .WIDTH       (W),
        .COUNT_WIDTH (CW)
    ) dut (
        .clockpulse   (clk),
        .clear        (clear),
        .start        (start),
        .ready        (ready),
        .loadWord     (load_word),
        .shiftCount   (shift_count),
        .fillMode     (fill_mode),
        .serialInput  (serial_input),
        .hold         (hold),
        .dataOut      (data_out),
        .serialOutput (serial_output),
        .serialValid  (serial_valid),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from an idle DUT and follow it to ready again.
    // Model: N=min(count,W) shifts, one per non-held edge, each producing a
    // strobe of the old MSB; then one done cycle; then ready.
    // start_mode: 0 start low while busy, 1 start held high, 2 random start.
    task automatic run_cmd(input logic [W-1:0] load, input logic [CW-1:0] cnt,
                           input logic [1:0] fm, input logic [31:0] sin_bits,
                           input logic [31:0] hold_bits, input int start_mode,
                           output int strobes, output int done_edge,
                           output logic [31:0] out_bits, output logic [W-1:0] final_word);
        int rem;
        int shifts;
        int word;
        int exp_bit;
        int fb;
        int n_edges;
        bit in_done;
        bit finished;
        bit hold_now;
        bit sin_now;
        bit exp_sv;
        bit exp_done;
        bit exp_ready;

        rem       = (int'(cnt) > int'(W)) ? int'(W) : int'(cnt);
        word      = int'(load);
        strobes   = 0;
        done_edge = -1;
        out_bits  = '0;
        shifts    = 0;
        in_done   = 1'b0;
        finished  = 1'b0;
        n_edges   = 0;

        check("ready_before_cmd", 32'(ready), 32'd1);
        start       = 1'b1;
        load_word   = load;
        shift_count = cnt;
        fill_mode   = fm;
        hold        = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        load_word   = ~load;
        shift_count = CW'($urandom);
        fill_mode   = 2'($urandom);
        check("accept_data", 32'(data_out), 32'(load));
        check("accept_ready", 32'(ready), 32'd0);
        check("accept_done", 32'(done), 32'd0);
        check("accept_valid", 32'(serial_valid), 32'd0);

        while (!finished && n_edges < 64) begin
            n_edges++;
            if (rem > 0 && n_edges <= 32) hold_now = hold_bits[n_edges-1];
            else if (rem > 0)             hold_now = 1'b0;
            else                          hold_now = 1'($urandom_range(0, 1));
            if (rem > 0 && shifts < 32) sin_now = sin_bits[shifts];
            else                        sin_now = 1'($urandom_range(0, 1));
            hold         = hold_now;
            serial_input = sin_now;
            case (start_mode)
                1:       start = 1'b1;
                2:       start = 1'($urandom_range(0, 1));
                default: start = 1'b0;
            endcase
            if (start_mode != 0) begin
                load_word   = W'($urandom);
                shift_count = CW'($urandom);
                fill_mode   = 2'($urandom);
            end
            @(negedge clk);

            exp_sv    = 1'b0;
            exp_done  = 1'b0;
            exp_ready = 1'b0;
            exp_bit   = 0;
            if (rem > 0) begin
                if (!hold_now) begin
                    exp_bit = (word >> (W - 1)) & 1;
                    case (fm)
                        2'b00:   fb = 0;
                        2'b01:   fb = 1;
                        2'b10:   fb = int'(sin_now);
                        default: fb = exp_bit;
                    endcase
                    word = (word * 2 + fb) % (1 << W);
                    rem--;
                    shifts++;
                    exp_sv = 1'b1;
                end
            end else if (!in_done) begin
                exp_done = 1'b1;
                in_done  = 1'b1;
            end else begin
                exp_ready = 1'b1;
                finished  = 1'b1;
            end

            check("serial_valid", 32'(serial_valid), 32'(exp_sv));
            check("done", 32'(done), 32'(exp_done));
            check("ready", 32'(ready), 32'(exp_ready));
            check("data_out", 32'(data_out), 32'(word));
            if (exp_sv) check("serial_out", 32'(serial_output), 32'(exp_bit));

            if (serial_valid === 1'b1) begin
                if (strobes < 32) out_bits[strobes] = serial_output;
                strobes++;
            end
            if (done === 1'b1 && done_edge < 0) done_edge = n_edges;
        end
        start = 1'b0;
        hold  = 1'b0;
        check("cmd_completes", 32'(finished), 32'd1);
        final_word = data_out;
    endtask

    initial begin
        int            s;
        int            d;
        int            n_exp;
        logic [31:0]   ob;
        logic [W-1:0]  fw;
        logic [W-1:0]  rl;
        logic [CW-1:0] rc;
        logic [1:0]    rf;

        clear        = 1'b0;
        start        = 1'b0;
        load_word    = '0;
        shift_count  = '0;
        fill_mode    = 2'b00;
        serial_input = 1'b0;
        hold         = 1'b0;

        // Reset state
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(serial_valid), 32'd0);
        check("rst_serial_out", 32'(serial_output), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);

        // Transmit 1011 with zero fill
        run_cmd(4'b1011, 3'd4, 2'b00, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("t1_bits", 32'(ob[3:0]), 32'b1101);
        check("t1_strobes", 32'(s), 32'd4);
        check("t1_done_edge", 32'(d), 32'd5);
        check("t1_final", 32'(fw), 32'b0000);

        // Single rotate
        run_cmd(4'b1000, 3'd1, 2'b11, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("t2_final", 32'(fw), 32'b0001);
        check("t2_strobes", 32'(s), 32'd1);
        check("t2_bit", 32'(ob[0]), 32'd1);

        // Full rotation restores the word
        run_cmd(4'b1001, 3'd4, 2'b11, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("t3_final", 32'(fw), 32'b1001);

        // Serial capture 1,1,0,1
        run_cmd(4'b0000, 3'd4, 2'b10, 32'b1011, 32'd0, 0, s, d, ob, fw);
        check("t4_final", 32'(fw), 32'b1101);

        // Count 7 clamps to 4, fill one
        run_cmd(4'b0110, 3'd7, 2'b01, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("t5_final", 32'(fw), 32'b1111);
        check("t5_strobes", 32'(s), 32'd4);
        check("t5_done_edge", 32'(d), 32'd5);

        // Zero count
        run_cmd(4'b0110, 3'd0, 2'b00, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("t6_final", 32'(fw), 32'b0110);
        check("t6_strobes", 32'(s), 32'd0);
        check("t6_done_edge", 32'(d), 32'd1);

        // Hold for two cycles after first shift, start held high while busy
        run_cmd(4'b1010, 3'd3, 2'b00, 32'd0, 32'b110, 1, s, d, ob, fw);
        check("t7_strobes", 32'(s), 32'd3);
        check("t7_done_edge", 32'(d), 32'd6);
        check("t7_bits", 32'(ob[2:0]), 32'b101);
        check("t7_final", 32'(fw), 32'b0000);

        // Clear mid-shift after the second shift
        start       = 1'b1;
        load_word   = 4'b1011;
        shift_count = 3'd4;
        fill_mode   = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_clear_data", 32'(data_out), 32'b1100);
        check("pre_clear_valid", 32'(serial_valid), 32'd1);
        #2;
        clear = 1'b0;
        #1;
        check("clear_data", 32'(data_out), 32'd0);
        check("clear_ready", 32'(ready), 32'd1);
        check("clear_valid", 32'(serial_valid), 32'd0);
        check("clear_serial_out", 32'(serial_output), 32'd0);
        check("clear_done", 32'(done), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        run_cmd(4'b0101, 3'd2, 2'b01, 32'd0, 32'd0, 0, s, d, ob, fw);
        check("post_clear_final", 32'(fw), 32'b0111);
        check("post_clear_bits", 32'(ob[1:0]), 32'b10);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            rl = W'($urandom);
            rc = CW'($urandom);
            rf = 2'($urandom);
            run_cmd(rl, rc, rf, $urandom, $urandom & $urandom & $urandom, 2, s, d, ob, fw);
            n_exp = (int'(rc) > int'(W)) ? int'(W) : int'(rc);
            check("rnd_strobes", 32'(s), 32'(n_exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
